// File: rtl/yuv_rgb_sram_if.sv
// SRAM-side bus of the YUV->RGB converter: start/done handshake plus one
// read port and one write port.
interface yuv_rgb_sram_if #(
   parameter int AW = 18,
   parameter int DW = 16
);
   logic          start;
   logic          done;
   logic [AW-1:0] raddr;
   logic [DW-1:0] rdata;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          wr_enable;

   // master: the converter, which drives the SRAM addresses
   modport master (input start, rdata, output done, raddr, waddr, wdata, wr_enable);
   // slave: the decompressor top / SRAM side
   modport slave  (output start, rdata, input done, raddr, waddr, wdata, wr_enable);
endinterface

// File: rtl/yuv_rgb_sram_converter.sv
// Reads planar full-resolution Y/U/V pixel pairs from SRAM, converts them to
// RGB888 (integer BT.601) and writes three packed words per pair back.
module yuv_rgb_sram_converter #(
   parameter int AW              = 18,
   parameter int DW              = 16,
   parameter int W               = 320,
   parameter int H               = 240,
   parameter int READ_ADDR_BASE  = 0,
   parameter int WRITE_ADDR_BASE = 115200
) (
   input  logic clk,
   input  logic reset,
   yuv_rgb_sram_if.master bus
);
   localparam int NP = W * H / 2;
   localparam int PW = (NP > 1) ? $clog2(NP) : 1;

   typedef enum logic [3:0] {IDLE, RD_Y, RD_U, RD_V, LAT_V, CALC, WR0, WR1, WR2, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   p_q, p_d;
   logic [DW-1:0]   y_q, y_d, u_q, u_d;
   logic [47:0]     rgb_q, rgb_d;
   logic [AW-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            wr_q, wr_d, done_q, done_d;
   logic [AW-1:0]   p_ext;
   logic            last_pair;

   function automatic logic [7:0] clamp8(input logic signed [19:0] x);
      if (x < 0)               return 8'd0;
      else if (x > 20'sd255)   return 8'hFF;
      else                     return x[7:0];
   endfunction

   // Intermediates are 20-bit signed: worst case 298*239+516*127+128 fits easily.
   function automatic logic [23:0] to_rgb(input logic [7:0] y, input logic [7:0] u,
                                          input logic [7:0] v);
      logic signed [19:0] c, d, e, r, g, b;
      c = $signed({12'd0, y}) - 20'sd16;
      d = $signed({12'd0, u}) - 20'sd128;
      e = $signed({12'd0, v}) - 20'sd128;
      r = (20'sd298 * c + 20'sd409 * e + 20'sd128) >>> 8;
      g = (20'sd298 * c - 20'sd100 * d - 20'sd208 * e + 20'sd128) >>> 8;
      b = (20'sd298 * c + 20'sd516 * d + 20'sd128) >>> 8;
      return {clamp8(r), clamp8(g), clamp8(b)};
   endfunction

   assign p_ext     = AW'(p_q);
   assign last_pair = (p_q == PW'(NP - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         p_q     <= '0;
         y_q     <= '0;
         u_q     <= '0;
         rgb_q   <= '0;
         raddr_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         y_q     <= y_d;
         u_q     <= u_d;
         rgb_q   <= rgb_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      y_d     = y_q;
      u_d     = u_q;
      rgb_d   = rgb_q;
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wr_d    = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         // done_q high means we are in the cycle the pulse is visible: ignore start then
         IDLE:  if (bus.start && !done_q) state_d = RD_Y;
         RD_Y:  begin raddr_d = AW'(READ_ADDR_BASE) + p_ext;          state_d = RD_U;  end
         RD_U:  begin raddr_d = AW'(READ_ADDR_BASE + NP) + p_ext;     state_d = RD_V;  end
         RD_V:  begin
            raddr_d = AW'(READ_ADDR_BASE + 2 * NP) + p_ext;
            y_d     = bus.rdata;
            state_d = LAT_V;
         end
         LAT_V: begin u_d = bus.rdata; state_d = CALC; end
         // V is consumed straight off the read bus as it arrives
         CALC:  begin
            rgb_d   = {to_rgb(y_q[15:8], u_q[15:8], bus.rdata[15:8]),
                       to_rgb(y_q[7:0],  u_q[7:0],  bus.rdata[7:0])};
            state_d = WR0;
         end
         WR0:   begin
            wr_d    = 1'b1;
            waddr_d = AW'(WRITE_ADDR_BASE) + p_ext * AW'(3);
            wdata_d = rgb_q[47:32];
            state_d = WR1;
         end
         WR1:   begin
            wr_d    = 1'b1;
            waddr_d = waddr_q + AW'(1);
            wdata_d = rgb_q[31:16];
            state_d = WR2;
         end
         WR2:   begin
            wr_d    = 1'b1;
            waddr_d = waddr_q + AW'(1);
            wdata_d = rgb_q[15:0];
            if (last_pair) state_d = DONE;
            else begin
               p_d     = p_q + PW'(1);
               state_d = RD_Y;
            end
         end
         DONE:  begin done_d = 1'b1; p_d = '0; state_d = IDLE; end
         default: state_d = IDLE;
      endcase
   end

   assign bus.raddr     = raddr_q;
   assign bus.waddr     = waddr_q;
   assign bus.wdata     = wdata_q;
   assign bus.wr_enable = wr_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_yuv_rgb_sram_converter.sv
// Self-checking bench: SRAM model, arithmetic reference model, directed and
// random frames on a 4x2 image.
module tb_yuv_rgb_sram_converter;
   localparam int AW = 18, DW = 16, W = 4, H = 2, RB = 0, WB = 115200;
   localparam int NP = W * H / 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   yuv_rgb_sram_if #(.AW(AW), .DW(DW)) sif ();

   yuv_rgb_sram_converter #(
      .AW(AW), .DW(DW), .W(W), .H(H), .READ_ADDR_BASE(RB), .WRITE_ADDR_BASE(WB)
   ) dut (
      .clk(clk), .reset(reset), .bus(sif)
   );

   int checks = 0, errors = 0, cyc = 0;
   logic [15:0] mem [int];
   int ra_at [int];
   int wc_q[$], wa_q[$], wd_q[$], dc_q[$];
   logic [7:0]  yp [2*NP], up [2*NP], vp [2*NP];
   logic [15:0] gold [3*NP];

   // SRAM model: read data valid the cycle after the address
   always @(posedge clk) begin
      sif.rdata <= mem.exists(int'(sif.raddr)) ? mem[int'(sif.raddr)] : 16'h0;
      if (sif.wr_enable) mem[int'(sif.waddr)] = sif.wdata;
   end

   always @(negedge clk) begin
      cyc++;
      ra_at[cyc] = int'(sif.raddr);
      if (sif.wr_enable) begin
         wc_q.push_back(cyc);
         wa_q.push_back(int'(sif.waddr));
         wd_q.push_back(int'(sif.wdata));
      end
      if (sif.done) dc_q.push_back(cyc);
   end

   function automatic logic [7:0] clip8(input int x);
      if (x < 0) return 8'd0;
      if (x > 255) return 8'd255;
      return 8'(x);
   endfunction

   function automatic logic [23:0] ref_rgb(input int y, input int u, input int v);
      int c, d, e;
      c = y - 16; d = u - 128; e = v - 128;
      return {clip8((298*c + 409*e + 128) >>> 8),
              clip8((298*c - 100*d - 208*e + 128) >>> 8),
              clip8((298*c + 516*d + 128) >>> 8)};
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic randomize_pixels();
      for (int i = 0; i < 2*NP; i++) begin
         yp[i] = 8'($urandom_range(0, 255));
         up[i] = 8'($urandom_range(0, 255));
         vp[i] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic load_frame();
      logic [23:0] a, b;
      for (int p = 0; p < NP; p++) begin
         mem[RB + p]        = {yp[2*p], yp[2*p+1]};
         mem[RB + NP + p]   = {up[2*p], up[2*p+1]};
         mem[RB + 2*NP + p] = {vp[2*p], vp[2*p+1]};
         a = ref_rgb(int'(yp[2*p]),   int'(up[2*p]),   int'(vp[2*p]));
         b = ref_rgb(int'(yp[2*p+1]), int'(up[2*p+1]), int'(vp[2*p+1]));
         gold[3*p]   = a[23:8];
         gold[3*p+1] = {a[7:0], b[23:16]};
         gold[3*p+2] = b[15:0];
      end
   endtask

   task automatic clear_logs();
      wc_q.delete(); wa_q.delete(); wd_q.delete(); dc_q.delete();
   endtask

   task automatic pulse_start(output int s);
      @(posedge clk); #1;
      sif.start = 1'b1;
      s = cyc + 1;
      @(posedge clk); #1;
      sif.start = 1'b0;
   endtask

   task automatic check_frame(input int s, input string tag);
      int n;
      while (dc_q.size() == 0 && cyc < s + 100) tick(1);
      tick(20);
      chk({tag, " done count"}, dc_q.size(), 1);
      if (dc_q.size() > 0) chk({tag, " done latency"}, dc_q[0] - s, 8*NP + 2);
      chk({tag, " write count"}, wc_q.size(), 3*NP);
      n = (wc_q.size() < 3*NP) ? wc_q.size() : 3*NP;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s waddr[%0d]", tag, i), wa_q[i], WB + i);
         chk($sformatf("%s wdata[%0d]", tag, i), wd_q[i], int'(gold[i]));
         chk($sformatf("%s wcycle[%0d]", tag, i), wc_q[i] - s, 7 + 8*(i/3) + i%3);
      end
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("%s raddr Y p%0d", tag, p), ra_at[s + 2 + 8*p], RB + p);
         chk($sformatf("%s raddr U p%0d", tag, p), ra_at[s + 3 + 8*p], RB + NP + p);
         chk($sformatf("%s raddr V p%0d", tag, p), ra_at[s + 4 + 8*p], RB + 2*NP + p);
      end
   endtask

   initial begin
      int s;
      logic [15:0] lit [9];
      lit = '{16'h0000, 16'h00FF, 16'hFFFF, 16'hFF00, 16'h00FF, 16'h0000,
              16'h0000, 16'h00FF, 16'h7DFF};
      sif.start = 1'b0;
      sif.rdata = '0;
      reset = 1'b1;
      tick(3);
      chk("reset wr_enable", int'(sif.wr_enable), 0);
      chk("reset done", int'(sif.done), 0);
      chk("reset raddr", int'(sif.raddr), 0);
      chk("reset waddr", int'(sif.waddr), 0);
      chk("reset wdata", int'(sif.wdata), 0);

      // start while reset is high must be lost
      clear_logs();
      sif.start = 1'b1;
      tick(1);
      sif.start = 1'b0;
      reset = 1'b0;
      tick(40);
      chk("start-in-reset writes", wc_q.size(), 0);
      chk("start-in-reset done", dc_q.size(), 0);

      // frame 1: black/white, saturated red, clamp extremes, random pair
      randomize_pixels();
      yp[0] = 8'h10; yp[1] = 8'hEB; up[0] = 8'h80; up[1] = 8'h80; vp[0] = 8'h80; vp[1] = 8'h80;
      yp[2] = 8'd81; yp[3] = 8'd81; up[2] = 8'd90; up[3] = 8'd90; vp[2] = 8'd240; vp[3] = 8'd240;
      yp[4] = 8'd0;  up[4] = 8'd128; vp[4] = 8'd128;
      yp[5] = 8'd255; up[5] = 8'd255; vp[5] = 8'd255;
      load_frame();
      clear_logs();
      pulse_start(s);
      tick(8);
      sif.start = 1'b1;
      tick(1);
      sif.start = 1'b0;
      while (cyc < s + 8*NP + 1) tick(1);
      sif.start = 1'b1;   // coincides with the done pulse
      tick(1);
      sif.start = 1'b0;
      check_frame(s, "f1");
      for (int i = 0; i < 9; i++)
         if (i < wd_q.size()) chk($sformatf("directed word %0d", i), wd_q[i], int'(lit[i]));

      // frame 2: fully random
      randomize_pixels();
      load_frame();
      clear_logs();
      pulse_start(s);
      check_frame(s, "f2");

      // reset during pair 2's first write
      randomize_pixels();
      load_frame();
      clear_logs();
      pulse_start(s);
      while (cyc < s + 22) tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(50);
      chk("midreset write count", wc_q.size(), 7);
      if (wc_q.size() > 0) chk("midreset last write cycle", wc_q[wc_q.size()-1] - s, 23);
      chk("midreset done", dc_q.size(), 0);

      // restart after reset converts from pair 0
      randomize_pixels();
      load_frame();
      clear_logs();
      pulse_start(s);
      check_frame(s, "f3");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/yuv_rgb_sram_converter.md
Name: yuv_rgb_sram_converter

Overview:
- Colour-space stage between the chroma upsampler and the SRAM-to-VGA controller.
- After the upsampler finishes, the block reads full-resolution planar Y/U/V from SRAM and converts each pixel to RGB888 (integer BT.601).
- It writes packed RGB back to SRAM for the VGA controller to scan out.
- It owns the SRAM ports only while the decompressor top has it selected: one start pulse in, one done pulse out.

Parameters:
AW, 18, SRAM address width
DW, 16, SRAM data width (fixed at 16; packing below assumes it)
W, 320, image width in pixels (even)
H, 240, image height in pixels
READ_ADDR_BASE, 0, word address of Y plane
WRITE_ADDR_BASE, 115200, word address of first RGB output word

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin conversion of a full frame
done  out  1  one-cycle pulse when last RGB word has been written
raddr  out  AW  SRAM read address
rdata  in  DW  SRAM read data; valid the cycle after raddr is presented
waddr  out  AW  SRAM write address
wdata  out  DW  SRAM write data
wr_enable  out  1  SRAM write strobe, one word per cycle

Behaviour:
- Reset is synchronous and active-high on clk. All outputs are registered and reset to 0. State resets to IDLE, and the pair counter resets to 0.
- Memory layout: NP = W*H/2 pixel pairs.
  - Y plane at READ_ADDR_BASE, U plane at READ_ADDR_BASE+NP, V plane at READ_ADDR_BASE+2*NP.
  - Each word holds two pixels: even pixel in [15:8], odd pixel in [7:0].
- Output: three words per pair p, at WRITE_ADDR_BASE+3p+{0,1,2}: {R0,G0}, {B0,R1}, {G1,B1}.
- Each pixel uses its own U/V sample (chroma is already full resolution).
- FSM (8 cycles per pair):
  - IDLE: on start go to RD_Y. Start is ignored in every other state.
  - RD_Y: raddr <= base+p.
  - RD_U: raddr <= base+NP+p.
  - RD_V: raddr <= base+2NP+p.
  - LAT_V: latch V.
  - CALC: register six clamped bytes.
  - WR0, WR1, WR2: wr_enable=1 with waddr/wdata per the layout above.
  - After WR2, if p==NP-1 go to DONE, else p++ and go to RD_Y.
  - DONE: done=1 for exactly one cycle, p <= 0, then IDLE.
- Capture timing: Y is captured from rdata in RD_V, U in LAT_V, V in CALC. Each value is the data returned for the address presented one cycle earlier. CALC uses the just-arriving V directly or adds a register; either is acceptable if the WR0 timing holds.
- wr_enable is 0 in all states except WR0–WR2. waddr/wdata are don't-care when wr_enable=0 but hold their last values.
- Arithmetic per pixel:
  - C=Y-16, D=U-128, E=V-128, all signed 10-bit.
  - R=(298C+409E+128)>>>8
  - G=(298C-100D-208E+128)>>>8
  - B=(298C+516D+128)>>>8
  - Intermediates are signed 20-bit, and the shift is arithmetic.
  - Clamp to 0..255: negative gives 0, >255 gives 255.
- Throughput: 8*NP cycles from start to done, plus 2 (IDLE exit, DONE). W=320, H=240 gives 307202 cycles.
- Boundary conditions:
  - start coincident with reset: reset wins.
  - Reset mid-frame: wr_enable=0 on the next edge and no done pulse; a later start restarts at pair 0.
  - start in the same cycle as done: ignored.
  - The final write address is WRITE_ADDR_BASE+3NP-1 = 230399 and must fit AW.

Test Plan:
- Black/white pair: Y[0]=0x10EB, U[0]=0x8080, V[0]=0x8080 -> words 0x0000, 0x00FF, 0xFFFF at 115200..115202.
- Saturated red: Y=81, U=90, V=240 on both pixels -> R=255, G=0, B=0; words 0xFF00, 0x00FF, 0x0000.
- Clamping: Y=0/U=128/V=128 -> 0,0,0; Y=255/U=255/V=255 -> 255,125,255.
- Full frame with W=4, H=2 (NP=4), random YUV:
  - 12 writes, at addresses WRITE_ADDR_BASE..+11, each matching the golden model.
  - done pulses exactly once, 34 cycles after start.
  - wr_enable pulses are grouped in bursts of 3, spaced 8 cycles apart.
- Protocol: start pulsed again during conversion -> no effect; raddr sequence is strictly Y, U, V per pair; no writes before the first CALC.
- Reset mid-frame at pair 2 -> wr_enable low next cycle and done stays 0; a new start re-converts from pair 0 with correct output.
